// File: rtl/recon_scheduler_if.sv
// recon_scheduler_if: upstream handshake and reconstructor control bundle for recon_scheduler.
interface recon_scheduler_if;
    logic        start;
    logic        res_valid;
    logic        res_ready;
    logic [1:0]  blk_type;
    logic        en_luma4x4;
    logic        en_chromab8x8;
    logic        en_chromar8x8;
    logic [31:0] mbnumber_luma4x4;
    logic [31:0] mbnumber_chroma8x8;
    logic        busy;
    logic        frame_done;
    modport master (
        input  start, res_valid,
        output res_ready, blk_type, en_luma4x4, en_chromab8x8, en_chromar8x8,
               mbnumber_luma4x4, mbnumber_chroma8x8, busy, frame_done
    );
    modport slave (
        output start, res_valid,
        input  res_ready, blk_type, en_luma4x4, en_chromab8x8, en_chromar8x8,
               mbnumber_luma4x4, mbnumber_chroma8x8, busy, frame_done
    );
endinterface

// File: rtl/recon_scheduler.sv
// recon_scheduler: walks a frame in macroblock raster order issuing 16 luma 4x4 + Cb + Cr blocks,
// holding off RECON_LATENCY cycles after each issue so neighbours are saved before the next block.
module recon_scheduler #(
    parameter int WIDTH         = 1280,
    parameter int LENGTH        = 720,
    parameter int RECON_LATENCY = 3
) (
    input logic clk,
    input logic reset,
    recon_scheduler_if.master bus
);
    localparam int MBX = WIDTH / 16;
    localparam int MBY = LENGTH / 16;
    localparam int XW  = $clog2(MBX + 1);
    localparam int YW  = $clog2(MBY + 1);
    localparam int CW  = $clog2(RECON_LATENCY + 1);
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE, DRAIN} state_t;
    state_t state, state_n;
    logic [XW-1:0] mbx;
    logic [YW-1:0] mby;
    logic [4:0]    sub;
    logic [CW-1:0] cnt;
    logic [31:0]   luma_idx, chroma_idx, mb_luma, mb_chroma;
    logic          last, drained, accept;
    assign luma_idx   = (32'(mby) * 32'd4 + 32'(sub[3:2])) * 32'(WIDTH / 4) + 32'(mbx) * 32'd4 + 32'(sub[1:0]);
    assign chroma_idx = 32'(mby) * 32'(MBX) + 32'(mbx);
    assign last       = sub == 5'd17 && mbx == XW'(MBX - 1) && mby == YW'(MBY - 1);
    assign drained    = state == DRAIN && cnt == CW'(1);
    assign accept     = state == WAIT && bus.res_valid;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? WAIT : IDLE;
            WAIT:    state_n = bus.res_valid ? ISSUE : WAIT;
            ISSUE:   state_n = DRAIN;
            default: state_n = !drained ? DRAIN : last ? IDLE : WAIT;
        endcase
    end
    assign bus.res_ready          = state == WAIT;
    assign bus.blk_type           = sub == 5'd16 ? 2'd1 : sub == 5'd17 ? 2'd2 : 2'd0;
    assign bus.en_luma4x4         = state == ISSUE && bus.blk_type == 2'd0;
    assign bus.en_chromab8x8      = state == ISSUE && bus.blk_type == 2'd1;
    assign bus.en_chromar8x8      = state == ISSUE && bus.blk_type == 2'd2;
    assign bus.mbnumber_luma4x4   = mb_luma;
    assign bus.mbnumber_chroma8x8 = mb_chroma;
    assign bus.busy               = state != IDLE;
    assign bus.frame_done         = drained && last;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mbx       <= '0;
            mby       <= '0;
            sub       <= '0;
            cnt       <= '0;
            mb_luma   <= '0;
            mb_chroma <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.start) begin
                mbx <= '0;
                mby <= '0;
                sub <= '0;
            end
            if (accept && sub < 5'd16)
                mb_luma <= luma_idx;
            if (accept && sub >= 5'd16)
                mb_chroma <= chroma_idx;
            cnt <= state == ISSUE ? CW'(RECON_LATENCY) : state == DRAIN ? cnt - CW'(1) : cnt;
            // The final Cr block leaves the counters parked; the next start clears them.
            if (drained && !last) begin
                sub <= sub == 5'd17 ? 5'd0 : sub + 5'd1;
                if (sub == 5'd17) begin
                    mbx <= mbx == XW'(MBX - 1) ? '0 : mbx + XW'(1);
                    if (mbx == XW'(MBX - 1))
                        mby <= mby + YW'(1);
                end
            end
        end
    end
endmodule
